// File: rtl/uart_cmd_handler.sv
// ============================================================================
// Module   : uart_cmd_handler (+ uart_rx, uart_tx primitives)
// Brief    : Binary UART command parser loading glitch timing registers.
//            Optional register readback when UART_CMD_READBACK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       valid,
    output logic [7:0] data
);
    localparam int CPB = CLK_FREQ / BAUD_RATE;
    localparam int CTW = $clog2(CPB + 1);

    logic [1:0]     sync;
    logic           active;
    logic [3:0]     idx;
    logic [CTW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync   <= 2'b11;
            active <= 1'b0;
            idx    <= 4'd0;
            cnt    <= '0;
            valid  <= 1'b0;
            data   <= 8'h00;
        end else begin
            sync  <= {sync[0], rx};
            valid <= 1'b0;
            if (!active) begin
                if (!sync[1]) begin
                    active <= 1'b1;
                    cnt    <= CTW'(CPB / 2);
                    idx    <= 4'd0;
                end
            end else if (cnt == '0) begin
                cnt <= CTW'(CPB - 1);
                idx <= idx + 4'd1;
                // idx 0 re-checks the start bit at mid-bit to reject glitches
                if (idx == 4'd0) begin
                    if (sync[1]) active <= 1'b0;
                end else if (idx <= 4'd8) begin
                    data <= {sync[1], data[7:1]};
                end else begin
                    active <= 1'b0;
                    valid  <= sync[1];
                end
            end else begin
                cnt <= cnt - CTW'(1);
            end
        end
    end
endmodule

module uart_tx #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy
);
    localparam int CPB = CLK_FREQ / BAUD_RATE;
    localparam int CTW = $clog2(CPB + 1);

    logic [8:0]     shreg;
    logic [3:0]     bitn;
    logic [CTW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx    <= 1'b1;
            busy  <= 1'b0;
            shreg <= 9'h1FF;
            bitn  <= 4'd0;
            cnt   <= '0;
        end else if (!busy) begin
            if (en) begin
                tx    <= 1'b0;
                busy  <= 1'b1;
                shreg <= {1'b1, data};
                bitn  <= 4'd9;
                cnt   <= CTW'(CPB - 1);
            end
        end else if (cnt == '0) begin
            cnt <= CTW'(CPB - 1);
            if (bitn == 4'd0) begin
                busy <= 1'b0;
            end else begin
                tx    <= shreg[0];
                shreg <= {1'b1, shreg[8:1]};
                bitn  <= bitn - 4'd1;
            end
        end else begin
            cnt <= cnt - CTW'(1);
        end
    end
endmodule

module uart_cmd_handler #(
    parameter int CLK_FREQ       = 50_000_000,
    parameter int BAUD_RATE      = 115200,
    parameter int DELAY_BYTES    = 2,
    parameter int WIDTH_BYTES    = 1,
    parameter int PULSES_BYTES   = 1,
    parameter int SPACING_BYTES  = 2,
    parameter int TIMEOUT_CYCLES = 500_000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       uart_rx_i,
    output logic                       uart_tx_o,
    output logic [8*DELAY_BYTES-1:0]   delay_o,
    output logic [8*WIDTH_BYTES-1:0]   width_o,
    output logic [8*PULSES_BYTES-1:0]  num_pulses_o,
    output logic [8*SPACING_BYTES-1:0] pulse_spacing_o,
    output logic                       pulse_en,
    output logic                       busy_o
);
    localparam int MAXB_A = (DELAY_BYTES > WIDTH_BYTES) ? DELAY_BYTES : WIDTH_BYTES;
    localparam int MAXB_B = (PULSES_BYTES > SPACING_BYTES) ? PULSES_BYTES : SPACING_BYTES;
    localparam int MAXB   = (MAXB_A > MAXB_B) ? MAXB_A : MAXB_B;
    localparam int SW     = 8 * MAXB;
    localparam int CW     = $clog2(MAXB + 1);
    localparam int TW     = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [7:0] CMD_DELAY = 8'h64, CMD_WIDTH = 8'h77, CMD_PULSES = 8'h6E;
    localparam logic [7:0] CMD_SPACE = 8'h73, CMD_ARM = 8'h67;
    localparam logic [7:0] RESP_ACK  = 8'h6B, RESP_NAK = 8'h3F;

    localparam logic [2:0] S_IDLE = 3'd0, S_PAYLOAD = 3'd1, S_RESP = 3'd2, S_GAP = 3'd3;
    localparam logic [2:0] T_DELAY = 3'd0, T_WIDTH = 3'd1, T_PULSES = 3'd2, T_SPACE = 3'd3;
`ifdef UART_CMD_READBACK_EN
    localparam logic [7:0] CMD_READ = 8'h72;
    localparam logic [2:0] S_RB = 3'd4, T_RSEL = 3'd4;
`endif

    logic          rx_valid, tx_busy, tx_en;
    logic [7:0]    rx_data, tx_data, resp;
    logic [2:0]    state, state_next, target;
    logic [SW-1:0] shadow, shadow_next;
    logic [CW-1:0] byte_cnt;
    logic [TW-1:0] tmo;
    logic          sel_ok;

    uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) u_rx (
        .clk(clk), .rst(rst), .rx(uart_rx_i), .valid(rx_valid), .data(rx_data)
    );

    uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) u_tx (
        .clk(clk), .rst(rst), .en(tx_en), .data(tx_data), .tx(uart_tx_o), .busy(tx_busy)
    );

    assign shadow_next = (shadow << 8) | SW'(rx_data);
    assign sel_ok = (rx_data == CMD_DELAY) || (rx_data == CMD_WIDTH) ||
                    (rx_data == CMD_PULSES) || (rx_data == CMD_SPACE);

`ifdef UART_CMD_READBACK_EN
    logic [SW-1:0] rb_val;
    logic [CW-1:0] rb_cnt;
    logic          rb_active;
    logic [7:0]    rb_byte;
    assign rb_byte = 8'(rb_val >> {rb_cnt - CW'(1), 3'b000});
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (rx_valid) begin
                    if (sel_ok) state_next = S_PAYLOAD;
`ifdef UART_CMD_READBACK_EN
                    else if (rx_data == CMD_READ) state_next = S_PAYLOAD;
`endif
                    else state_next = S_RESP;
                end
            end
            S_PAYLOAD: begin
                if (rx_valid) begin
                    if (byte_cnt == CW'(1)) begin
                        state_next = S_RESP;
`ifdef UART_CMD_READBACK_EN
                        if (target == T_RSEL && sel_ok) state_next = S_RB;
`endif
                    end
                end else if (tmo == TW'(1)) begin
                    state_next = S_RESP;
                end
            end
            S_RESP: if (!tx_busy) state_next = S_GAP;
`ifdef UART_CMD_READBACK_EN
            S_GAP:  state_next = rb_active ? S_RB : S_IDLE;
            S_RB:   state_next = S_RESP;
`else
            S_GAP:  state_next = S_IDLE;
`endif
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            delay_o         <= '0;
            width_o         <= '0;
            num_pulses_o    <= '0;
            pulse_spacing_o <= '0;
            pulse_en        <= 1'b0;
            tx_en           <= 1'b0;
            tx_data         <= 8'h00;
            resp            <= 8'h00;
            target          <= T_DELAY;
            shadow          <= '0;
            byte_cnt        <= '0;
            tmo             <= '0;
`ifdef UART_CMD_READBACK_EN
            rb_val          <= '0;
            rb_cnt          <= '0;
            rb_active       <= 1'b0;
`endif
        end else begin
            pulse_en <= 1'b0;
            tx_en    <= 1'b0;
            case (state)
                S_IDLE: if (rx_valid) begin
                    shadow   <= '0;
                    tmo      <= TW'(TIMEOUT_CYCLES);
                    resp     <= (rx_data == CMD_ARM) ? RESP_ACK : RESP_NAK;
                    pulse_en <= (rx_data == CMD_ARM);
                    case (rx_data)
                        CMD_DELAY:  begin target <= T_DELAY;  byte_cnt <= CW'(DELAY_BYTES);   end
                        CMD_WIDTH:  begin target <= T_WIDTH;  byte_cnt <= CW'(WIDTH_BYTES);   end
                        CMD_PULSES: begin target <= T_PULSES; byte_cnt <= CW'(PULSES_BYTES);  end
                        CMD_SPACE:  begin target <= T_SPACE;  byte_cnt <= CW'(SPACING_BYTES); end
`ifdef UART_CMD_READBACK_EN
                        CMD_READ:   begin target <= T_RSEL;   byte_cnt <= CW'(1);             end
`endif
                        default: ;
                    endcase
                end
                S_PAYLOAD: begin
                    if (rx_valid) begin
                        shadow   <= shadow_next;
                        byte_cnt <= byte_cnt - CW'(1);
                        tmo      <= TW'(TIMEOUT_CYCLES);
                        if (byte_cnt == CW'(1)) begin
                            resp <= RESP_ACK;
                            case (target)
                                T_DELAY:  delay_o         <= shadow_next[8*DELAY_BYTES-1:0];
                                T_WIDTH:  width_o         <= shadow_next[8*WIDTH_BYTES-1:0];
                                T_PULSES: num_pulses_o    <= shadow_next[8*PULSES_BYTES-1:0];
                                T_SPACE:  pulse_spacing_o <= shadow_next[8*SPACING_BYTES-1:0];
`ifdef UART_CMD_READBACK_EN
                                T_RSEL: begin
                                    resp      <= RESP_NAK;
                                    rb_active <= sel_ok;
                                    case (rx_data)
                                        CMD_DELAY:  begin rb_val <= SW'(delay_o);         rb_cnt <= CW'(DELAY_BYTES);   end
                                        CMD_WIDTH:  begin rb_val <= SW'(width_o);         rb_cnt <= CW'(WIDTH_BYTES);   end
                                        CMD_PULSES: begin rb_val <= SW'(num_pulses_o);    rb_cnt <= CW'(PULSES_BYTES);  end
                                        CMD_SPACE:  begin rb_val <= SW'(pulse_spacing_o); rb_cnt <= CW'(SPACING_BYTES); end
                                        default: ;
                                    endcase
                                end
`endif
                                default: ;
                            endcase
                        end
                    end else if (tmo == TW'(1)) begin
                        resp <= RESP_NAK;
                    end else begin
                        tmo <= tmo - TW'(1);
                    end
                end
                S_RESP: if (!tx_busy) begin
                    tx_en   <= 1'b1;
                    tx_data <= resp;
                end
`ifdef UART_CMD_READBACK_EN
                // Emit remaining value bytes MSB first, then the trailing ACK
                S_RB: begin
                    if (rb_cnt != '0) begin
                        resp   <= rb_byte;
                        rb_cnt <= rb_cnt - CW'(1);
                    end else begin
                        resp      <= RESP_ACK;
                        rb_active <= 1'b0;
                    end
                end
`endif
                default: ;
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_uart_cmd_handler.sv
// ============================================================================
// Module   : tb_uart_cmd_handler
// Brief    : Directed self-checking bench driving uart_cmd_handler serially.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_cmd_handler;
    localparam int CPB = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        uart_rx_i = 1'b1;
    logic        uart_tx_o;
    logic [15:0] delay_o;
    logic [7:0]  width_o;
    logic [7:0]  num_pulses_o;
    logic [15:0] pulse_spacing_o;
    logic        pulse_en;
    logic        busy_o;

    int total = 0;
    int bad   = 0;
    int pe_cnt = 0;
    int pe_base;
    logic [7:0] rxq[$];

    uart_cmd_handler #(
        .CLK_FREQ(1_000_000), .BAUD_RATE(100_000),
        .DELAY_BYTES(2), .WIDTH_BYTES(1), .PULSES_BYTES(1), .SPACING_BYTES(2),
        .TIMEOUT_CYCLES(1000)
    ) dut (
        .clk(clk), .rst(rst), .uart_rx_i(uart_rx_i), .uart_tx_o(uart_tx_o),
        .delay_o(delay_o), .width_o(width_o), .num_pulses_o(num_pulses_o),
        .pulse_spacing_o(pulse_spacing_o), .pulse_en(pulse_en), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (pulse_en) pe_cnt <= pe_cnt + 1;

    // Serial receiver model: samples each bit at mid-bit
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge uart_tx_o);
            if (!rst) begin
                repeat (CPB / 2) @(posedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(posedge clk);
                    b[i] = uart_tx_o;
                end
                rxq.push_back(b);
                repeat (CPB) @(posedge clk);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        uart_rx_i = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx_i = b[i];
            repeat (CPB) @(posedge clk);
        end
        uart_rx_i = 1'b1;
        repeat (CPB + 2) @(posedge clk);
    endtask

    task automatic expect_tx(input string tag, input logic [7:0] exp);
        int n = 0;
        while (rxq.size() == 0 && n < 5000) begin
            @(posedge clk);
            n++;
        end
        if (rxq.size() == 0) check(tag, 32'h100, {24'h0, exp});
        else                 check(tag, {24'h0, rxq.pop_front()}, {24'h0, exp});
        repeat (2 * CPB) @(posedge clk);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("rst_delay", delay_o, 0);
        check("rst_width", width_o, 0);
        check("rst_pulses", num_pulses_o, 0);
        check("rst_spacing", pulse_spacing_o, 0);
        check("rst_pe", pulse_en, 0);
        check("rst_busy", busy_o, 0);
        check("rst_txline", uart_tx_o, 1);

        send_byte(8'h64); send_byte(8'h12); send_byte(8'h34);
        expect_tx("delay_ack", 8'h6B);
        check("delay_val", delay_o, 32'h1234);
        check("delay_other_w", width_o, 0);
        check("delay_other_s", pulse_spacing_o, 0);

        pe_base = pe_cnt;
        send_byte(8'h77); send_byte(8'hA5);
        expect_tx("width_ack", 8'h6B);
        check("width_val", width_o, 32'hA5);
        send_byte(8'h67);
        expect_tx("arm_ack", 8'h6B);
        check("arm_pulse_cycles", pe_cnt - pe_base, 1);

        send_byte(8'h55);
        expect_tx("unknown_nak", 8'h3F);
        check("unknown_delay", delay_o, 32'h1234);
        check("unknown_width", width_o, 32'hA5);

        pe_base = pe_cnt;
        send_byte(8'h77); send_byte(8'h67);
        expect_tx("width_cmdbyte_ack", 8'h6B);
        check("width_cmdbyte_val", width_o, 32'h67);
        check("width_cmdbyte_nopulse", pe_cnt - pe_base, 0);

        send_byte(8'h6E); send_byte(8'h07);
        expect_tx("pulses_ack", 8'h6B);
        check("pulses_val", num_pulses_o, 7);

        send_byte(8'h73); send_byte(8'h01);
        expect_tx("timeout_nak", 8'h3F);
        check("timeout_spacing", pulse_spacing_o, 0);
        send_byte(8'h73); send_byte(8'h00); send_byte(8'h10);
        expect_tx("spacing_ack", 8'h6B);
        check("spacing_val", pulse_spacing_o, 32'h0010);

        send_byte(8'h64); send_byte(8'hFF);
        @(posedge clk); #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_delay", delay_o, 0);
        check("midrst_width", width_o, 0);
        check("midrst_spacing", pulse_spacing_o, 0);
        rst = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        check("midrst_busy", busy_o, 0);
        check("midrst_no_tx", rxq.size(), 0);
        send_byte(8'h64); send_byte(8'h00); send_byte(8'h05);
        expect_tx("postrst_ack", 8'h6B);
        check("postrst_delay", delay_o, 5);

`ifdef UART_CMD_READBACK_EN
        send_byte(8'h64); send_byte(8'h12); send_byte(8'h34);
        expect_tx("rb_set_ack", 8'h6B);
        send_byte(8'h72); send_byte(8'h64);
        expect_tx("rb_msb", 8'h12);
        expect_tx("rb_lsb", 8'h34);
        expect_tx("rb_ack", 8'h6B);
        send_byte(8'h72); send_byte(8'h41);
        expect_tx("rb_badsel_nak", 8'h3F);
`else
        send_byte(8'h72);
        expect_tx("rb_disabled_nak", 8'h3F);
`endif
        repeat (200) @(posedge clk);
        check("no_extra_tx", rxq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/uart_cmd_handler.md
# uart_cmd_handler

Parametrised successor to the echo-only UART front end. It parses a binary command stream from the host PC and loads the glitch timing registers (delay, width, pulse count, pulse spacing). Each register update is atomic, and the block issues an arm strobe. It answers every command with ACK/NAK, and optionally supports register readback. It sits between the `uart_rx`/`uart_tx` primitives, which it instantiates, and the pulse generator.

## Interface
- `CLK_FREQ`, 50_000_000, system clock in Hz; passed to `uart_rx`/`uart_tx`.
- `BAUD_RATE`, 115200, serial rate; passed to `uart_rx`/`uart_tx`.
- `DELAY_BYTES`, 2, payload bytes of delay register; width is 8*`DELAY_BYTES`.
- `WIDTH_BYTES`, 1, payload bytes of width register.
- `PULSES_BYTES`, 1, payload bytes of pulse-count register.
- `SPACING_BYTES`, 2, payload bytes of spacing register.
- `TIMEOUT_CYCLES`, 500_000, maximum clk cycles allowed between payload bytes; must be ≥ 1.
- `clk` in 1: single system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `uart_rx_i` in 1: serial input from the host.
- `uart_tx_o` out 1: serial output to the host.
- `delay_o` out 8*`DELAY_BYTES`: committed trigger-to-first-pulse delay.
- `width_o` out 8*`WIDTH_BYTES`: committed pulse width.
- `num_pulses_o` out 8*`PULSES_BYTES`: committed pulse count.
- `pulse_spacing_o` out 8*`SPACING_BYTES`: committed inter-pulse spacing.
- `pulse_en` out 1: one-cycle arm strobe.
- `busy_o` out 1: high whenever the state is not IDLE.

## Operation
- Commands: 0x64 'd' delay, 0x77 'w' width, 0x6E 'n' pulses, 0x73 's' spacing; each is followed by that register's byte count of payload, MSB first.
- Command 0x67 'g' is arm, with no payload.
- Responses: ACK = 0x6B 'k'; NAK = 0x3F '?'.
- States:
  - IDLE: on rx_valid, decode the byte.
    - Register command: clear the shadow register, load the byte counter with the register's byte count, go to PAYLOAD.
    - 'g': pulse `pulse_en`, queue ACK, go to RESP.
    - Unknown byte: queue NAK, go to RESP.
  - PAYLOAD: on each rx_valid, shift the byte in (`shadow <= {shadow, byte}`), decrement the counter, and reload the timeout counter.
    - On the final byte, commit the shadow to the target output in one cycle, queue ACK, go to RESP.
    - If the timeout counter hits 0, discard the shadow (outputs unchanged), queue NAK, go to RESP.
  - RESP: when tx is not busy, drive the queued byte with `uart_tx_en` high for one cycle, go to GAP.
  - GAP: wait one cycle (this masks tx_busy latency), then return to IDLE, or to RB when readback bytes remain.
- Payload bytes are raw binary. Any value is accepted, including bytes equal to command codes.
- Bytes received in RESP, GAP or RB are dropped silently; the host must wait for the response.
- Output registers change only on a commit or on reset. A partial or timed-out command never changes an output.
- The shadow register is as wide as the widest register. On commit, the shadow's low 8*N bits go to the target register.

## Timing
- Reset (async assert, sync release) forces:
  - `delay_o`, `width_o`, `num_pulses_o`, `pulse_spacing_o` = 0
  - `pulse_en` = 0, `busy_o` = 0
  - `uart_tx_en` = 0, tx data = 0
  - state = IDLE
  - `uart_tx_o` idles high (from `uart_tx` reset).
- Reset mid-command aborts the command with no response and clears all registers.
- Final payload byte rx_valid at cycle T:
  - T+1: new value visible on the output, state RESP.
  - T+2 at earliest: `uart_tx_en` high.
- 'g' byte rx_valid at T: `pulse_en` high only during T+1; ACK tx_en at T+2 at earliest.
- Timeout: a NAK follows `TIMEOUT_CYCLES` cycles after the last payload byte's rx_valid, or after the command byte's rx_valid if no payload byte arrived.
- Only one tx byte is issued per RESP→GAP pass. Successive response bytes are separated by at least one frame.

## Configuration
- `UART_CMD_READBACK_EN` defined:
  - Command 0x72 'r' plus one selector byte ('d'/'w'/'n'/'s') returns that register's committed value, MSB first, followed by ACK, via the RB state.
  - An invalid selector returns NAK.
  - The selector byte is subject to the same timeout as payload bytes.
- `UART_CMD_READBACK_EN` undefined: 'r' is an unknown command, answered with NAK; no RB state and no readback mux are synthesised.

## Test plan
- Set delay, defaults, DELAY_BYTES=2: send 0x64 0x12 0x34 → `delay_o` = 0x1234 one cycle after the last byte; tx returns 0x6B; other outputs stay 0.
- Set width, then arm: send 0x77 0xA5, then 0x67 → `width_o` = 0xA5; `pulse_en` high for exactly one cycle; two 0x6B responses.
- Unknown command: send 0x55 → tx 0x3F; all outputs unchanged.
- Timeout, TIMEOUT_CYCLES=1000: send 0x73 0x01, then idle for more than 1000 cycles → tx 0x3F; `pulse_spacing_o` keeps its prior value; then 0x73 0x00 0x10 → 0x0010 and 0x6B.
- Reset mid-payload: assert `rst` after 0x64 0xFF → all outputs 0, no tx activity, `busy_o` = 0; the next 0x64 0x00 0x05 gives `delay_o` = 5.
- Readback, with macro: after delay = 0x1234, send 0x72 0x64 → tx 0x12, 0x34, 0x6B. Without macro: send 0x72 → tx 0x3F.
